// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
// Shared types and constants for the 4-digit 7-segment scan controller.
//   NUM_DIGITS   : number of multiplexed digits on the board
//   load_state_t : states of the value-load sequencer
//   digit_code_t : 5-bit display code; bit4 marks a special glyph,
//                  5'h10 is the dash used for decimal overflow
//   SEG_BLANK    : all segments (and dp) off, active-low
//   SEG_DASH     : centre segment only, dp off, active-low
// ---------------------------------------------------------------------------
package fnd_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_LOAD    = 2'd2
    } load_state_t;

    typedef logic [4:0] digit_code_t;

    localparam digit_code_t CODE_DASH = 5'h10;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

endpackage : fnd_pkg

// File: rtl/fnd_seg_decode.sv
// ---------------------------------------------------------------------------
// fnd_seg_decode
// Combinational digit-code to 7-segment decoder, active-low outputs.
//   code     in  5  digit code (0-F hex glyphs, 5'h10 dash)
//   segments out 7  active-low segments, [6:0] = g..a
// Unused special codes decode to all segments off.
// ---------------------------------------------------------------------------
module fnd_seg_decode
    import fnd_pkg::*;
(
    input  digit_code_t code,
    output logic [6:0]  segments
);

    always_comb begin
        segments = SEG_BLANK[6:0];
        case (code)
            5'h00:     segments = 7'h40;
            5'h01:     segments = 7'h79;
            5'h02:     segments = 7'h24;
            5'h03:     segments = 7'h30;
            5'h04:     segments = 7'h19;
            5'h05:     segments = 7'h12;
            5'h06:     segments = 7'h02;
            5'h07:     segments = 7'h78;
            5'h08:     segments = 7'h00;
            5'h09:     segments = 7'h10;
            5'h0A:     segments = 7'h08;
            5'h0B:     segments = 7'h03;
            5'h0C:     segments = 7'h46;
            5'h0D:     segments = 7'h21;
            5'h0E:     segments = 7'h06;
            5'h0F:     segments = 7'h0E;
            CODE_DASH: segments = SEG_DASH[6:0];
            default:   segments = SEG_BLANK[6:0];
        endcase
    end

endmodule : fnd_seg_decode

// File: rtl/fnd_scan_controller.sv
// ---------------------------------------------------------------------------
// fnd_scan_controller
// Loads a 16-bit value into a 4-digit display buffer (hex, or decimal via a
// sequential double-dabble converter) and time-multiplexes it onto
// common-anode 7-segment pins with decimal-point and blink masks.
//   ACLK           in   1   system clock
//   ARESETN        in   1   asynchronous active-low reset
//   cfg_enable     in   1   display on; 0 blanks pins and holds scan at start
//   cfg_dec_mode   in   1   1 = decimal, 0 = hex (sampled on load)
//   cfg_value      in  16   value to display (sampled on load)
//   cfg_dp_mask    in   4   decimal point per digit, bit0 = rightmost
//   cfg_blink_mask in   4   digits blanked during blink phase 1
//   cfg_update     in   1   single-cycle load request
//   busy           out  1   load sequencer not idle
//   fnd_com        out  4   active-low digit select, bit0 = rightmost
//   fnd_seg        out  8   active-low segments, [7] = dp
// ---------------------------------------------------------------------------
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int BLINK_TICKS = 250
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        cfg_enable,
    input  logic        cfg_dec_mode,
    input  logic [15:0] cfg_value,
    input  logic [3:0]  cfg_dp_mask,
    input  logic [3:0]  cfg_blink_mask,
    input  logic        cfg_update,
    output logic        busy,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_seg
);

    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    // ---------------- load sequencer ----------------
    load_state_t load_state_reg;
    logic [15:0] shift_reg;
    // Five BCD nibbles so any 16-bit value converts without loss; a nonzero
    // top nibble means the value does not fit in four decimal digits.
    logic [19:0] bcd_reg;
    logic [19:0] bcd_adj;
    logic [3:0]  iter_reg;
    logic        dec_reg;
    logic        pending_reg;

    digit_code_t [NUM_DIGITS-1:0] disp_buf_reg;
    digit_code_t [NUM_DIGITS-1:0] load_codes;

    genvar gi;

    // Add-3 correction for every nibble that would overflow past 9 on shift.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // In hex mode the shift register is never shifted, so it still holds the
    // latched value when LOAD writes the buffer.
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_code
            assign load_codes[gi] = !dec_reg                ? {1'b0, shift_reg[4*gi +: 4]}
                                  : (bcd_reg[19:16] != 4'd0) ? CODE_DASH
                                  :                            {1'b0, bcd_reg[4*gi +: 4]};
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            load_state_reg <= ST_IDLE;
            shift_reg      <= '0;
            bcd_reg        <= '0;
            iter_reg       <= '0;
            dec_reg        <= 1'b0;
            pending_reg    <= 1'b0;
            disp_buf_reg   <= '0;
        end else begin
            case (load_state_reg)
                ST_IDLE: begin
                    // A request deferred while busy is replayed here using
                    // whatever value/mode is presented in this cycle.
                    if (cfg_update || pending_reg) begin
                        shift_reg      <= cfg_value;
                        dec_reg        <= cfg_dec_mode;
                        pending_reg    <= 1'b0;
                        bcd_reg        <= '0;
                        iter_reg       <= '0;
                        load_state_reg <= cfg_dec_mode ? ST_CONVERT : ST_LOAD;
                    end
                end
                ST_CONVERT: begin
                    bcd_reg   <= {bcd_adj[18:0], shift_reg[15]};
                    shift_reg <= {shift_reg[14:0], 1'b0};
                    iter_reg  <= iter_reg + 4'd1;
                    if (iter_reg == 4'd15) begin
                        load_state_reg <= ST_LOAD;
                    end
                    if (cfg_update) begin
                        pending_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Whole buffer written in one edge so the scan never
                    // shows a mix of old and new digits.
                    disp_buf_reg   <= load_codes;
                    load_state_reg <= ST_IDLE;
                    if (cfg_update) begin
                        pending_reg <= 1'b1;
                    end
                end
                default: begin
                    load_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (load_state_reg != ST_IDLE);

    // ---------------- digit scan ----------------
    logic [PRESC_W-1:0] presc_reg;
    logic [1:0]         idx_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               phase_reg;
    logic               scan_tick;
    logic               blink_term;
    logic [6:0]         seg_glyph;

    assign scan_tick  = (presc_reg == PRESC_W'(SCAN_DIV - 1));
    assign blink_term = (blink_cnt_reg == BLINK_W'(BLINK_TICKS - 1));

    fnd_seg_decode u_decode (
        .code     (disp_buf_reg[idx_reg]),
        .segments (seg_glyph)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            presc_reg     <= '0;
            idx_reg       <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            fnd_com       <= 4'hF;
            fnd_seg       <= SEG_BLANK;
        end else if (!cfg_enable) begin
            // Hold everything at the start of a fresh slot so re-enable
            // begins with digit 0 for a full slot.
            presc_reg     <= '0;
            idx_reg       <= '0;
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            fnd_com       <= 4'hF;
            fnd_seg       <= SEG_BLANK;
        end else begin
            fnd_com <= ~(4'b0001 << idx_reg);
            if (cfg_blink_mask[idx_reg] && phase_reg) begin
                fnd_seg <= SEG_BLANK;
            end else begin
                fnd_seg <= {~cfg_dp_mask[idx_reg], seg_glyph};
            end

            if (scan_tick) begin
                presc_reg <= '0;
                idx_reg   <= idx_reg + 2'd1;
                if (blink_term) begin
                    blink_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
                end
            end else begin
                presc_reg <= presc_reg + PRESC_W'(1);
            end
        end
    end

endmodule : fnd_scan_controller
